// File: rtl/ext_wb_pkg.sv
// ext_wb_pkg: shared types and helpers for the ext -> Wishbone master bridge.
//   wb_state_t         : bridge FSM states (IDLE, BUS, RESP)
//   DEFAULT_*_WIDTH    : default address/data widths
//   timeout_cnt_width(): width of the optional bus-cycle watchdog counter
package ext_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Counter must reach cycles-1; never let the width collapse to zero.
  function automatic int timeout_cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/ext_wb_timeout.sv
// ext_wb_timeout: bus-cycle watchdog for ext_wb_master (used only when
// EXT_WB_TIMEOUT_EN is defined).
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : hold the count at zero (bridge not in a bus cycle)
//   enable       : count this edge (bus cycle still waiting for ack/err)
//   expired      : this edge is the LIMIT-th waiting edge
module ext_wb_timeout
  import ext_wb_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = timeout_cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_reg;

  assign expired = enable && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (clear || expired) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/ext_wb_master.sv
// ext_wb_master: responder for the ext valid/ready request interface that
// issues one single-beat Wishbone B4 classic cycle per ext request.
// Optional feature macro: EXT_WB_TIMEOUT_EN (bus-cycle watchdog).
//   clk, reset_n          : clock, asynchronous active-low reset
//   ext_valid/ext_ready   : request handshake (ready is a one-cycle pulse)
//   ext_write, ext_address, ext_write_data, ext_write_strobe : request fields
//   ext_read_data, ext_error : completion results, valid while ext_ready=1
//   wbm_*                 : Wishbone master port (all outputs registered)
module ext_wb_master
  import ext_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic                  ext_write,
  input  logic [ADDR_WIDTH-1:0] ext_address,
  input  logic [DATA_WIDTH-1:0] ext_write_data,
  input  logic [SEL_WIDTH-1:0]  ext_write_strobe,
  output logic [DATA_WIDTH-1:0] ext_read_data,
  output logic                  ext_error,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  output logic [SEL_WIDTH-1:0]  wbm_sel_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i
);

  wb_state_t             state_reg;
  logic                  ready_reg;
  logic                  error_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  cyc_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] adr_reg;
  logic [DATA_WIDTH-1:0] dat_reg;
  logic [SEL_WIDTH-1:0]  sel_reg;
  logic                  timeout_hit;

`ifdef EXT_WB_TIMEOUT_EN
  // Count only edges where the slave has not answered; any answer wins.
  ext_wb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_reg != ST_BUS),
    .enable  ((state_reg == ST_BUS) && !wbm_ack_i && !wbm_err_i),
    .expired (timeout_hit)
  );
`else
  // Without the watchdog a silent slave stalls the bridge indefinitely.
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
      rdata_reg <= '0;
      cyc_reg   <= 1'b0;
      we_reg    <= 1'b0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      sel_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ext_valid) begin
            we_reg    <= ext_write;
            adr_reg   <= ext_address;
            dat_reg   <= ext_write_data;
            sel_reg   <= ext_write_strobe;
            cyc_reg   <= 1'b1;
            state_reg <= ST_BUS;
          end
        end
        ST_BUS: begin
          // err outranks ack (a stray ack+err completes as an error),
          // and both outrank the watchdog.
          if (wbm_err_i || wbm_ack_i || timeout_hit) begin
            error_reg <= wbm_err_i || !wbm_ack_i;
            rdata_reg <= (!wbm_err_i && wbm_ack_i && !we_reg) ? wbm_dat_i : '0;
            ready_reg <= 1'b1;
            cyc_reg   <= 1'b0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            state_reg <= ST_RESP;
          end
        end
        ST_RESP: begin
          // rdata_reg deliberately holds until the next completion.
          ready_reg <= 1'b0;
          error_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ext_ready     = ready_reg;
  assign ext_error     = error_reg;
  assign ext_read_data = rdata_reg;
  assign wbm_cyc_o     = cyc_reg;
  assign wbm_stb_o     = cyc_reg;   // single-beat classic: stb tracks cyc
  assign wbm_we_o      = we_reg;
  assign wbm_adr_o     = adr_reg;
  assign wbm_dat_o     = dat_reg;
  assign wbm_sel_o     = sel_reg;

endmodule

// File: tb/tb_ext_wb_master.sv
// tb_ext_wb_master: self-checking bench for ext_wb_master. A behavioural
// slave answers each request after a chosen number of stb cycles; the
// expected completion (latency, data, error) is derived from the bridge's
// rules per transaction.
module tb_ext_wb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic          clk;
  logic          reset_n;
  logic          ext_valid;
  logic          ext_ready;
  logic          ext_write;
  logic [AW-1:0] ext_address;
  logic [DW-1:0] ext_write_data;
  logic [SW-1:0] ext_write_strobe;
  logic [DW-1:0] ext_read_data;
  logic          ext_error;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [SW-1:0] wbm_sel_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;
  logic          wbm_err_i;

  int total = 0;
  int bad   = 0;

  ext_wb_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .SEL_WIDTH      (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ext_valid        (ext_valid),
    .ext_ready        (ext_ready),
    .ext_write        (ext_write),
    .ext_address      (ext_address),
    .ext_write_data   (ext_write_data),
    .ext_write_strobe (ext_write_strobe),
    .ext_read_data    (ext_read_data),
    .ext_error        (ext_error),
    .wbm_cyc_o        (wbm_cyc_o),
    .wbm_stb_o        (wbm_stb_o),
    .wbm_we_o         (wbm_we_o),
    .wbm_adr_o        (wbm_adr_o),
    .wbm_dat_o        (wbm_dat_o),
    .wbm_sel_o        (wbm_sel_o),
    .wbm_dat_i        (wbm_dat_i),
    .wbm_ack_i        (wbm_ack_i),
    .wbm_err_i        (wbm_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end (observed=hang required=finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One ext request; the slave answers in stb cycle 'dly' (0 = first).
  // Expected results come from the bridge rules, not from the DUT.
  task automatic txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                     input logic [SW-1:0] sel, input int dly, input logic ack,
                     input logic err, input logic [DW-1:0] sdat);
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    exp_err = err;
    exp_rd  = (err || we) ? '0 : sdat;
    ext_valid        = 1'b1;
    ext_write        = we;
    ext_address      = adr;
    ext_write_data   = wd;
    ext_write_strobe = sel;
    step();                                  // valid sampled: bus cycle starts
    chk("cyc_start", wbm_cyc_o, 1'b1);
    chk("stb_start", wbm_stb_o, 1'b1);
    chk("we_o", wbm_we_o, we);
    chk("adr_o", wbm_adr_o, adr);
    chk("dat_o", wbm_dat_o, wd);
    chk("sel_o", wbm_sel_o, sel);
    for (int k = 0; k < dly; k++) begin
      chk("ready_wait", ext_ready, 1'b0);
      chk("cyc_wait", wbm_cyc_o, 1'b1);
      step();
    end
    wbm_ack_i = ack;
    wbm_err_i = err;
    wbm_dat_i = sdat;
    step();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = $urandom;
    chk("ready_pulse", ext_ready, 1'b1);
    chk("cyc_end", wbm_cyc_o, 1'b0);
    chk("stb_end", wbm_stb_o, 1'b0);
    chk("we_end", wbm_we_o, 1'b0);
    chk("rdata", ext_read_data, exp_rd);
    chk("error", ext_error, exp_err);
    $display("txn we=%0b adr=%08h wd=%08h sel=%h dly=%0d ack=%0b err=%0b -> rd=%08h err=%0b",
             we, adr, wd, sel, dly, ack, err, ext_read_data, ext_error);
    ext_valid = 1'b0;
    step();                                  // the single idle cycle
    chk("ready_drop", ext_ready, 1'b0);
    chk("error_drop", ext_error, 1'b0);
    chk("rdata_hold", ext_read_data, exp_rd);
    chk("cyc_idle", wbm_cyc_o, 1'b0);
  endtask

  initial begin
    int rdy_seen;
    int cyc_cnt;
    reset_n          = 1'b0;
    ext_valid        = 1'b0;
    ext_write        = 1'b0;
    ext_address      = '0;
    ext_write_data   = '0;
    ext_write_strobe = '0;
    wbm_dat_i        = '0;
    wbm_ack_i        = 1'b0;
    wbm_err_i        = 1'b0;
    #1;
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_ready", ext_ready, 1'b0);
    chk("rst_adr", wbm_adr_o, '0);
    chk("rst_rdata", ext_read_data, '0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Directed cases.
    txn(1'b0, 32'h0000_1000, 32'h0, 4'hF, 2, 1'b1, 1'b0, 32'hDEAD_BEEF);
    txn(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0101, 0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    txn(1'b0, 32'h0000_3008, 32'h0, 4'hF, 1, 1'b1, 1'b1, 32'hCAFE_F00D);
    txn(1'b0, 32'h0000_300C, 32'h0, 4'hF, 0, 1'b0, 1'b1, 32'h5555_AAAA);
    // Back-to-back reads with immediate ack.
    txn(1'b0, 32'h0000_4000, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'h1111_1111);
    txn(1'b0, 32'h0000_4004, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'h2222_2222);

    // Stray ack/err while idle must not produce a completion.
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    step();
    chk("stray_ready", ext_ready, 1'b0);
    chk("stray_cyc", wbm_cyc_o, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 20; i++) begin
      logic e;
      e = ($urandom_range(0, 3) == 0);
      txn(1'(($urandom) & 1), $urandom, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 4), e ? 1'(($urandom) & 1) : 1'b1, e, $urandom);
    end

    // Silent slave.
    ext_valid   = 1'b1;
    ext_write   = 1'b0;
    ext_address = 32'h0000_5000;
    ext_write_strobe = 4'hF;
    step();
    ext_valid = 1'b0;
`ifdef EXT_WB_TIMEOUT_EN
    cyc_cnt  = 0;
    rdy_seen = 0;
    for (int k = 0; k < 40 && rdy_seen == 0; k++) begin
      if (ext_ready) rdy_seen = 1;
      else begin
        if (wbm_cyc_o) cyc_cnt++;
        step();
      end
    end
    chk("to_ready", rdy_seen, 1);
    chk("to_cyc_cycles", cyc_cnt, TO);
    chk("to_error", ext_error, 1'b1);
    chk("to_rdata", ext_read_data, '0);
    $display("timeout read cyc_cycles=%0d err=%0b", cyc_cnt, ext_error);
    step();
`else
    rdy_seen = 0;
    cyc_cnt  = 0;
    for (int k = 0; k < 1000; k++) begin
      if (ext_ready) rdy_seen++;
      if (wbm_cyc_o) cyc_cnt++;
      step();
    end
    chk("noto_ready", rdy_seen, 0);
    chk("noto_cyc_cycles", cyc_cnt, 1000);
    $display("silent slave cyc_cycles=%0d ready_count=%0d", cyc_cnt, rdy_seen);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
`endif

    // Reset three cycles into a bus cycle.
    ext_valid   = 1'b1;
    ext_write   = 1'b1;
    ext_address = 32'h0000_6000;
    ext_write_data = 32'hA5A5_5A5A;
    ext_write_strobe = 4'hF;
    step();
    step();
    step();
    chk("pre_rst_cyc", wbm_cyc_o, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cyc", wbm_cyc_o, 1'b0);
    chk("mid_rst_stb", wbm_stb_o, 1'b0);
    chk("mid_rst_ready", ext_ready, 1'b0);
    ext_valid = 1'b0;
    step();
    reset_n = 1'b1;
    wbm_ack_i = 1'b1;                        // late ack from the aborted slave
    step();
    wbm_ack_i = 1'b0;
    rdy_seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (ext_ready) rdy_seen++;
      step();
    end
    chk("late_ack_ready", rdy_seen, 0);
    $display("reset mid-cycle ready_count=%0d", rdy_seen);
    txn(1'b0, 32'h0000_7000, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h0BAD_C0DE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_wb_master.md
Name: ext_wb_master

Overview:
Bridges the core-style ext request interface onto a Wishbone classic (B4, non-pipelined) master port.
- The ext side is a valid/ready initiator; this block is its responder.
- The block turns each ext request into exactly one single-beat Wishbone cycle towards external slaves (user-area peripherals, memories).
- It is the opposite end of the ext interface from the slave-side Wishbone hookup that drives the core.

Parameters:
ADDR_WIDTH, 32, ext/Wishbone address width
DATA_WIDTH, 32, data width; must be a multiple of 8
SEL_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT_CYCLES, 256, bus-cycle watchdog limit; used only with EXT_WB_TIMEOUT_EN

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  reset, asynchronous assert, active low
ext_valid  in  1  request present; held with its fields stable until ext_ready
ext_ready  out  1  one-cycle completion pulse
ext_write  in  1  1=write, 0=read
ext_address  in  ADDR_WIDTH  byte address
ext_write_data  in  DATA_WIDTH  write data
ext_write_strobe  in  SEL_WIDTH  byte enables
ext_read_data  out  DATA_WIDTH  read data; valid while ext_ready=1
ext_error  out  1  completion was err/timeout; valid while ext_ready=1
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable
wbm_adr_o  out  ADDR_WIDTH  address
wbm_dat_o  out  DATA_WIDTH  write data
wbm_sel_o  out  SEL_WIDTH  byte select
wbm_dat_i  in  DATA_WIDTH  read data
wbm_ack_i  in  1  slave acknowledge
wbm_err_i  in  1  slave error

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM=IDLE, timeout counter 0. Applies immediately, including mid-cycle: cyc/stb drop without waiting for ack; the in-flight request is lost and no ext_ready is issued.
- FSM has three states: IDLE, BUS, RESP.
- IDLE: on edge with ext_valid=1, register we/adr/dat/sel from ext fields, set cyc=stb=1, go to BUS.
  - wbm_* are registered outputs; they change only on the IDLE->BUS and BUS->RESP transitions.
- BUS: cyc=stb=1 with fields held. On each edge:
  - wbm_err_i=1: capture error=1 and read data 0; go to RESP.
  - else wbm_ack_i=1: capture error=0; read data = wbm_dat_i for reads, 0 for writes; go to RESP.
  - else (EXT_WB_TIMEOUT_EN only) counter==TIMEOUT_CYCLES-1: error=1, read data 0; go to RESP.
  - else counter++.
- Priority within one edge: err > ack > timeout.
- On leaving BUS: cyc, stb, we, sel cleared to 0; adr and dat_o may hold.
- RESP: ext_ready=1 for exactly one cycle, with ext_read_data and ext_error valid; counter cleared; go to IDLE.
  - ext_read_data holds its value until the next completion.
  - ext_error returns to 0 after RESP.
- Latency: ext_valid sampled at edge N gives cyc from N+1. Ack sampled at edge M (M≥N+1) gives ext_ready high in cycle M+1.
  - Minimum valid-to-ready is 2 cycles.
  - Back-to-back requests have one IDLE cycle between Wishbone cycles.
- Initiator must deassert ext_valid, or present a new request, in the cycle after ext_ready. A request still valid in IDLE is treated as new.
- ext_valid dropped while in BUS is ignored; the cycle completes normally.
- ack/err arriving in IDLE or RESP is ignored.
- Stray ack with err in the same edge: completion is reported as error.

Optional Feature:
EXT_WB_TIMEOUT_EN
- Defined: watchdog counter of width $clog2(TIMEOUT_CYCLES) is instantiated. A BUS state lasting TIMEOUT_CYCLES edges without ack/err aborts the cycle with ext_error=1 and read data 0.
- Undefined: no counter logic; BUS waits indefinitely for ack/err, and ext_error is asserted only by wbm_err_i.

Decomposition:
- Package ext_wb_pkg holds:
  - FSM state enum (IDLE, BUS, RESP);
  - localparam defaults for ADDR/DATA width;
  - function computing the timeout counter width.
- One sub-module, ext_wb_timeout: counter with clear/enable/expired, instantiated only under EXT_WB_TIMEOUT_EN.

Test Plan:
- Read 0x0000_1000; slave acks 2 cycles after stb with dat 0xDEADBEEF -> wbm_we_o=0, sel=4'hF; ext_ready one cycle with read_data 0xDEADBEEF, ext_error=0; cyc low same cycle as ready.
- Write 0x0000_2004, data 0x1234_5678, strobe 4'b0101; slave acks in first stb cycle -> wbm_we_o=1, sel=0101, dat_o=0x12345678; ready 2 cycles after valid sampled; read_data 0.
- Read with wbm_err_i and wbm_ack_i both high on the same edge -> ext_ready with ext_error=1, read_data 0.
- EXT_WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave silent -> cyc high exactly 8 cycles, then ext_ready with ext_error=1. Without the macro, cyc stays high for 1000 cycles with no ready.
- reset_n pulsed low 3 cycles into BUS -> cyc/stb/ext_ready 0 immediately; late ack after reset release produces no ext_ready; next request completes normally.
- Two back-to-back reads with immediate ack -> exactly one ext_ready per request; second cyc rises 1 idle cycle after first ready.
